line_axil_bridge: RTL and testbench



---
 rtl/memory_pkg.sv | 32 +++
 rtl/line_axil_bridge_if.sv | 74 +++++++
 rtl/line_axil_bridge.sv | 174 +++++++++++++++++
 tb/tb_line_axil_bridge.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: shared types and sizes for the line cache memory side.
// Line/strobe bundles, beat sizing and the line bridge state enum.
package memory_pkg;

  localparam int ADDR_W         = 64;
  localparam int DATA_W         = 64;
  localparam int OFFSET_BITS    = 7;
  localparam int STRB_W         = DATA_W / 8;
  localparam int WORDS_PER_LINE = (1 << OFFSET_BITS) / STRB_W;
  localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
  localparam int LINE_W         = WORDS_PER_LINE * DATA_W;
  localparam int LSTRB_W        = WORDS_PER_LINE * STRB_W;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [STRB_W-1:0]  strb_t;
  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [LSTRB_W-1:0] line_strb_t;
  typedef logic [BEAT_W-1:0]  beat_t;

  localparam addr_t OFF_MASK =
    addr_t'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_AR,
    S_RD_R,
    S_WR_AWW,
    S_WR_B
  } line_bridge_state_t;

endpackage

// File: rtl/line_axil_bridge_if.sv
// line_req_if: bulk line request/response (master = cache, slave = bridge).
// axil_if: single-word AXI-lite (master = bridge, slave = memory).
interface line_req_if;
  import memory_pkg::*;

  logic       req_valid;
  logic       req_ready;
  addr_t      req_addr;
  logic       req_write;
  line_t      req_wdata;
  line_strb_t req_wstrb;
  logic       resp_valid;
  line_t      resp_rdata;

  modport master (
    output req_valid, req_addr, req_write,
    output req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_write,
    input  req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

interface axil_if;
  import memory_pkg::*;

  logic       m_awvalid;
  logic       m_awready;
  addr_t      m_awaddr;
  logic       m_wvalid;
  logic       m_wready;
  word_t      m_wdata;
  strb_t      m_wstrb;
  logic       m_bvalid;
  logic       m_bready;
  logic [1:0] m_bresp;
  logic       m_arvalid;
  logic       m_arready;
  addr_t      m_araddr;
  logic       m_rvalid;
  logic       m_rready;
  word_t      m_rdata;
  logic [1:0] m_rresp;

  modport master (
    output m_awvalid, m_awaddr,
    input  m_awready,
    output m_wvalid, m_wdata, m_wstrb,
    input  m_wready,
    input  m_bvalid, m_bresp,
    output m_bready,
    output m_arvalid, m_araddr,
    input  m_arready,
    input  m_rvalid, m_rdata, m_rresp,
    output m_rready
  );

  modport slave (
    input  m_awvalid, m_awaddr,
    output m_awready,
    input  m_wvalid, m_wdata, m_wstrb,
    output m_wready,
    output m_bvalid, m_bresp,
    input  m_bready,
    input  m_arvalid, m_araddr,
    output m_arready,
    output m_rvalid, m_rdata, m_rresp,
    input  m_rready
  );
endinterface

// File: rtl/line_axil_bridge.sv
// line_axil_bridge: splits whole-line fills/writebacks into per-word AXI-lite.
// Ports: clk, rst (sync, active-high); req (line_req_if.slave);
// m (axil_if.master); busy (not idle); err (sticky nonzero bresp/rresp).
// Option LINE_AXIL_BRIDGE_SKIP_ZERO_STRB_EN: zero-strobe beats skip the bus.
module line_axil_bridge
  import memory_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  line_req_if.slave    req,
  axil_if.master       m,
  output logic         busy,
  output logic         err
);

  line_bridge_state_t state_q, state_d;
  beat_t      beat_q, beat_d;
  addr_t      base_q, base_d;
  line_t      wdata_q, wdata_d;
  line_strb_t wstrb_q, wstrb_d;
  line_t      fill_q, fill_d;
  line_t      rdata_q, rdata_d;
  logic       resp_q, resp_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic       err_q, err_d;

  addr_t beat_addr;
  word_t cur_wdata;
  strb_t cur_wstrb;
  logic  last;
  logic  skip;

  assign beat_addr = base_q
    + (addr_t'(beat_q) * addr_t'(STRB_W));
  assign cur_wdata =
    wdata_q[int'(beat_q)*DATA_W +: DATA_W];
  assign cur_wstrb =
    wstrb_q[int'(beat_q)*STRB_W +: STRB_W];
  assign last =
    (beat_q == beat_t'(WORDS_PER_LINE - 1));

`ifdef LINE_AXIL_BRIDGE_SKIP_ZERO_STRB_EN
  assign skip = (cur_wstrb == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    fill_d    = fill_q;
    rdata_d   = rdata_q;
    resp_d    = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;

    req.req_ready = 1'b0;
    m.m_arvalid   = 1'b0;
    m.m_araddr    = beat_addr;
    m.m_rready    = 1'b0;
    m.m_awvalid   = 1'b0;
    m.m_awaddr    = beat_addr;
    m.m_wvalid    = 1'b0;
    m.m_wdata     = cur_wdata;
    m.m_wstrb     = cur_wstrb;
    m.m_bready    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid) begin
          base_d    = req.req_addr & ~OFF_MASK;
          wdata_d   = req.req_wdata;
          wstrb_d   = req.req_wstrb;
          beat_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req.req_write ? S_WR_AWW
                                    : S_RD_AR;
        end
      end
      S_RD_AR: begin
        m.m_arvalid = 1'b1;
        if (m.m_arready) state_d = S_RD_R;
      end
      S_RD_R: begin
        m.m_rready = 1'b1;
        if (m.m_rvalid) begin
          fill_d[int'(beat_q)*DATA_W +: DATA_W] =
            m.m_rdata;
          if (m.m_rresp != 2'b00) err_d = 1'b1;
          if (last) begin
            // publish the whole line at once so
            // resp_rdata never shows a partial fill
            rdata_d = fill_d;
            resp_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_RD_AR;
          end
        end
      end
      S_WR_AWW: begin
        if (skip) begin
          if (last) state_d = S_IDLE;
          else      beat_d  = beat_q + 1'b1;
        end else begin
          m.m_awvalid = !aw_done_q;
          m.m_wvalid  = !w_done_q;
          aw_done_d = aw_done_q | m.m_awready;
          w_done_d  = w_done_q  | m.m_wready;
          if (aw_done_d && w_done_d) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WR_B;
          end
        end
      end
      S_WR_B: begin
        m.m_bready = 1'b1;
        if (m.m_bvalid) begin
          if (m.m_bresp != 2'b00) err_d = 1'b1;
          if (last) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = S_WR_AWW;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      fill_q    <= '0;
      rdata_q   <= '0;
      resp_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      fill_q    <= fill_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  assign req.resp_valid = resp_q;
  assign req.resp_rdata = rdata_q;
  assign busy = (state_q != S_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_line_axil_bridge.sv
// tb_line_axil_bridge: random/directed bench with an AXI-lite memory model.
// Golden line memory is updated per request and compared to the bus memory.
module tb_line_axil_bridge;
  import memory_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;
  int   checks = 0;
  int   failures = 0;
  longint cyc = 0;

  line_req_if rq();
  axil_if     ax();

  line_axil_bridge dut (
    .clk  (clk),
    .rst  (rst),
    .req  (rq),
    .m    (ax),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_t mem[addr_t];
  word_t gold[addr_t];

  bit    stall_en = 0;
  bit    bad_en = 0;
  addr_t bad_addr = '0;
  int    resp_cnt = 0;
  longint resp_cyc = 0;
  longint acc_cyc = 0;
  int    busy_cnt = 0;
  int    b_cnt = 0;
  line_t last_resp = '0;
  addr_t ar_log[$];
  addr_t aw_log[$];
  word_t w_log[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  endtask

  function automatic word_t dflt(addr_t a);
    return {a[31:0] ^ 32'h5a5a_0000, ~a[31:0]};
  endfunction

  function automatic word_t mem_rd(addr_t a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic word_t gold_rd(addr_t a);
    return gold.exists(a) ? gold[a] : dflt(a);
  endfunction

  function automatic word_t merge(word_t o, word_t n,
                                  strb_t s);
    word_t r;
    r = o;
    for (int b = 0; b < STRB_W; b++)
      if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic int pick();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // ---------------- AXI-lite memory model ----------------
  addr_t arq[$];
  addr_t awq[$];
  word_t wdq[$];
  strb_t wsq[$];
  int    bpend = 0;
  int    arst = 0, awst = 0, wst = 0;
  int    rdly = 0, bdly = 0;
  logic  ar_hs, aw_hs, w_hs, r_hs, b_hs, rst_s;
  addr_t ar_a, aw_a;
  word_t w_d;
  strb_t w_s;
  logic  pv_ar = 0, pv_aw = 0, pv_w = 0, pv_rst = 1;
  addr_t pv_ara, pv_awa;
  word_t pv_wd;
  strb_t pv_ws;

  initial begin : responder
    ax.m_arready = 1'b1;
    ax.m_awready = 1'b1;
    ax.m_wready  = 1'b1;
    ax.m_rvalid  = 1'b0;
    ax.m_rdata   = '0;
    ax.m_rresp   = 2'b00;
    ax.m_bvalid  = 1'b0;
    ax.m_bresp   = 2'b00;
    forever begin
      @(negedge clk);
      rst_s = rst;
      ar_hs = ax.m_arvalid && ax.m_arready;
      aw_hs = ax.m_awvalid && ax.m_awready;
      w_hs  = ax.m_wvalid && ax.m_wready;
      r_hs  = ax.m_rvalid && ax.m_rready;
      b_hs  = ax.m_bvalid && ax.m_bready;
      ar_a = ax.m_araddr;
      aw_a = ax.m_awaddr;
      w_d  = ax.m_wdata;
      w_s  = ax.m_wstrb;
      if (!pv_rst && !rst_s) begin
        if (pv_ar) begin
          chk("ar_hold", 64'(ax.m_arvalid), 64'd1);
          chk("ar_addr_hold", ar_a, pv_ara);
        end
        if (pv_aw) begin
          chk("aw_hold", 64'(ax.m_awvalid), 64'd1);
          chk("aw_addr_hold", aw_a, pv_awa);
        end
        if (pv_w) begin
          chk("w_hold", 64'(ax.m_wvalid), 64'd1);
          chk("w_data_hold", w_d, pv_wd);
          chk("w_strb_hold", 64'(w_s), 64'(pv_ws));
        end
      end
      if (rq.resp_valid) begin
        resp_cnt++;
        resp_cyc  = cyc;
        last_resp = rq.resp_rdata;
      end
      if (busy) busy_cnt++;
      pv_ar  = ax.m_arvalid && !ar_hs;
      pv_aw  = ax.m_awvalid && !aw_hs;
      pv_w   = ax.m_wvalid && !w_hs;
      pv_ara = ar_a;
      pv_awa = aw_a;
      pv_wd  = w_d;
      pv_ws  = w_s;
      pv_rst = rst_s;
      @(posedge clk);
      #1;
      if (rst_s) begin
        arq.delete(); awq.delete();
        wdq.delete(); wsq.delete();
        bpend = 0; rdly = 0; bdly = 0;
        arst = 0; awst = 0; wst = 0;
        ax.m_rvalid  = 1'b0;
        ax.m_bvalid  = 1'b0;
        ax.m_arready = 1'b1;
        ax.m_awready = 1'b1;
        ax.m_wready  = 1'b1;
        continue;
      end
      if (ar_hs) begin
        arq.push_back(ar_a);
        ar_log.push_back(ar_a);
      end
      if (aw_hs) begin
        awq.push_back(aw_a);
        aw_log.push_back(aw_a);
      end
      if (w_hs) begin
        wdq.push_back(w_d);
        wsq.push_back(w_s);
        w_log.push_back(w_d);
      end
      if (r_hs) ax.m_rvalid = 1'b0;
      if (b_hs) begin
        ax.m_bvalid = 1'b0;
        b_cnt++;
      end
      if (awq.size() > 0 && wdq.size() > 0) begin
        addr_t a;
        a = awq.pop_front();
        mem[a] = merge(mem_rd(a), wdq.pop_front(),
                       wsq.pop_front());
        bpend++;
      end
      if (!ax.m_rvalid && arq.size() > 0) begin
        if (rdly > 0) rdly--;
        else begin
          addr_t a;
          a = arq.pop_front();
          ax.m_rvalid = 1'b1;
          ax.m_rdata  = mem_rd(a);
          ax.m_rresp  = (bad_en && a == bad_addr)
                        ? 2'b10 : 2'b00;
          rdly = pick();
        end
      end
      if (!ax.m_bvalid && bpend > 0) begin
        if (bdly > 0) bdly--;
        else begin
          bpend--;
          ax.m_bvalid = 1'b1;
          ax.m_bresp  = 2'b00;
          bdly = pick();
        end
      end
      if (ar_hs) arst = pick();
      else if (arst > 0) arst--;
      if (aw_hs) awst = pick();
      else if (awst > 0) awst--;
      if (w_hs) wst = pick();
      else if (wst > 0) wst--;
      ax.m_arready = (arst == 0);
      ax.m_awready = (awst == 0);
      ax.m_wready  = (wst == 0);
    end
  end

  // ---------------- line request driver ----------------
  task automatic do_line(input bit wr, input addr_t a,
                         input line_t wd,
                         input line_strb_t ws);
    addr_t base;
    int    n;
    int    rc0;
    base = a & ~OFF_MASK;
    rc0  = resp_cnt;
    @(posedge clk);
    #1;
    rq.req_valid = 1'b1;
    rq.req_addr  = a;
    rq.req_write = wr;
    rq.req_wdata = wd;
    rq.req_wstrb = ws;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rq.req_ready && n < 2000);
    acc_cyc  = cyc;
    busy_cnt = 0;
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    if (wr) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        addr_t wa;
        wa = base + addr_t'(w * STRB_W);
        gold[wa] = merge(gold_rd(wa),
                         wd[w*DATA_W +: DATA_W],
                         ws[w*STRB_W +: STRB_W]);
      end
    end
    if (wr) begin
      do begin
        @(negedge clk);
        n++;
      end while (busy && n < 2000);
    end else begin
      while (resp_cnt == rc0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
    end
    if (n >= 2000) begin
      chk("line_timeout", 64'd0, 64'd1);
      finish_tb();
    end
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      addr_t wa;
      wa = base + addr_t'(w * STRB_W);
      if (wr)
        chk("mem_word", mem_rd(wa), gold_rd(wa));
      else
        chk("fill_word", last_resp[w*DATA_W +: DATA_W],
            gold_rd(wa));
    end
  endtask

  // ---------------- test sequence ----------------
  line_t      wd;
  line_strb_t ws;
  addr_t      b1;
  int         rc;
  int         n;
  int         exp_tx;

  initial begin : main
    rst = 1'b1;
    rq.req_valid = 1'b0;
    rq.req_addr  = '0;
    rq.req_write = 1'b0;
    rq.req_wdata = '0;
    rq.req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(rq.req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_resp_valid", 64'(rq.resp_valid), 64'd0);
    chk("rst_rdata_zero", 64'(rq.resp_rdata == '0), 64'd1);
    chk("rst_arvalid", 64'(ax.m_arvalid), 64'd0);
    chk("rst_awvalid", 64'(ax.m_awvalid), 64'd0);
    chk("rst_wvalid", 64'(ax.m_wvalid), 64'd0);

    // directed zero-wait fill
    b1 = 64'h1234_5678_9ABC_DE00;
    for (int k = 0; k < WORDS_PER_LINE; k++) begin
      mem[b1 + addr_t'(8*k)]  = 64'hA000 + 64'(k);
      gold[b1 + addr_t'(8*k)] = 64'hA000 + 64'(k);
    end
    ar_log.delete();
    rc = resp_cnt;
    do_line(0, 64'h1234_5678_9ABC_DE50, '0, '0);
    chk("fill_latency", 64'(resp_cyc - acc_cyc), 64'd33);
    chk("fill_w5", last_resp[5*DATA_W +: DATA_W], 64'hA005);
    chk("ar_count", 64'(ar_log.size()), 64'd16);
    for (int k = 0; k < ar_log.size(); k++)
      chk("ar_addr", ar_log[k], b1 + addr_t'(8*k));
    repeat (5) @(negedge clk);
    chk("fill_pulse_once", 64'(resp_cnt - rc), 64'd1);

    // directed zero-wait writeback
    for (int k = 0; k < WORDS_PER_LINE; k++)
      wd[k*DATA_W +: DATA_W] = 64'(k) * 64'h0101;
    aw_log.delete();
    w_log.delete();
    rc = resp_cnt;
    do_line(1, 64'h400, wd, '1);
    chk("wb_busy_cycles", 64'(busy_cnt), 64'd32);
    chk("wb_aw_count", 64'(aw_log.size()), 64'd16);
    chk("wb_w_count", 64'(w_log.size()), 64'd16);
    for (int k = 0; k < aw_log.size(); k++)
      chk("wb_aw_addr", aw_log[k], 64'h400 + 64'(8*k));
    for (int k = 0; k < w_log.size(); k++)
      chk("wb_w_data", w_log[k], 64'(k) * 64'h0101);
    repeat (3) @(negedge clk);
    chk("wb_no_resp", 64'(resp_cnt), 64'(rc));

    // random mixed lines with random stalls
    stall_en = 1;
    for (int i = 0; i < 100; i++) begin
      bit    wr;
      addr_t a;
      wr = 1'($urandom_range(0, 1));
      a  = 64'h8000 + 64'(128 * $urandom_range(0, 7))
           + 64'($urandom_range(0, 127));
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        wd[w*DATA_W +: DATA_W] = {$urandom(), $urandom()};
        ws[w*STRB_W +: STRB_W] =
          ($urandom_range(0, 3) == 0) ? 8'h00
                                      : 8'($urandom());
      end
      do_line(wr, a, wd, ws);
    end
    chk("err_clean", 64'(err), 64'd0);

    // rresp error on beat 3
    stall_en = 0;
    bad_addr = 64'h9000 + 64'd24;
    bad_en   = 1;
    do_line(0, 64'h9005, '0, '0);
    chk("err_set", 64'(err), 64'd1);
    bad_en = 0;
    do_line(0, 64'h9080, '0, '0);
    chk("err_sticky", 64'(err), 64'd1);

    // reset during beat 7 of a fill
    rc = resp_cnt;
    ar_log.delete();
    @(posedge clk);
    #1;
    rq.req_valid = 1'b1;
    rq.req_write = 1'b0;
    rq.req_addr  = 64'hA000;
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    n = 0;
    while (ar_log.size() < 8 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_reached", 64'(ar_log.size() >= 8), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(rq.req_ready), 64'd1);
    chk("rst_mid_arvalid", 64'(ax.m_arvalid), 64'd0);
    chk("rst_mid_rready", 64'(ax.m_rready), 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_mid_no_resp", 64'(resp_cnt), 64'(rc));

    // sparse strobes: only words 2 and 9
    ws = '0;
    ws[2*STRB_W +: STRB_W] = 8'hFF;
    ws[9*STRB_W +: STRB_W] = 8'hFF;
    for (int w = 0; w < WORDS_PER_LINE; w++)
      wd[w*DATA_W +: DATA_W] = {$urandom(), $urandom()};
`ifdef LINE_AXIL_BRIDGE_SKIP_ZERO_STRB_EN
    exp_tx = 2;
`else
    exp_tx = 16;
`endif
    aw_log.delete();
    w_log.delete();
    b_cnt = 0;
    do_line(1, 64'h2000, wd, ws);
    chk("sparse_aw_count", 64'(aw_log.size()), 64'(exp_tx));
    chk("sparse_w_count", 64'(w_log.size()), 64'(exp_tx));
    chk("sparse_b_count", 64'(b_cnt), 64'(exp_tx));

    finish_tb();
  end

endmodule
